// File: rtl/uart_sample_packer_pkg.sv
// Shared constants and types for the UART audio sample packer.
// Defines the pairing FSM states, the data widths and the byte-pair packing helper.
package uart_sample_packer_pkg;

    localparam int unsigned SAMPLE_W         = 16;
    localparam int unsigned BYTE_W           = 8;
    localparam int unsigned DEF_FIFO_AW      = 3;
    localparam int unsigned DEF_IDLE_TIMEOUT = 78125;

    typedef enum logic {
        WAIT_LO = 1'b0,
        WAIT_HI = 1'b1
    } pair_state_e;

    // Samples arrive little-endian: the low byte comes first on the line.
    function automatic logic [SAMPLE_W-1:0] pack_sample(input logic [BYTE_W-1:0] hi,
                                                        input logic [BYTE_W-1:0] lo);
        return {hi, lo};
    endfunction

endpackage

// File: rtl/uart_sample_packer_if.sv
// Bundle of the byte-input, sample-request and status signals for the sample packer.
// The master side feeds bytes and requests; the slave side is the packer itself.
interface uart_sample_packer_if #(
    parameter int unsigned FIFO_AW = 3
);
    import uart_sample_packer_pkg::*;

    logic [BYTE_W-1:0]   rx_data;
    logic                rx_valid;
    logic                sample_req;
    logic                clear;
    logic [SAMPLE_W-1:0] sample;
    logic                sample_valid;
    logic [FIFO_AW:0]    level;
    logic                overflow;
    logic                underrun;

    modport master (
        output rx_data,
        output rx_valid,
        output sample_req,
        output clear,
        input  sample,
        input  sample_valid,
        input  level,
        input  overflow,
        input  underrun
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        input  sample_req,
        input  clear,
        output sample,
        output sample_valid,
        output level,
        output overflow,
        output underrun
    );

endinterface

// File: rtl/uart_sample_packer_sample_fifo.sv
// Power-of-two sample FIFO with a registered read port.
// A push into a full FIFO is still accepted when a pop frees a slot in the same cycle.
module sample_fifo
    import uart_sample_packer_pkg::*;
#(
    parameter int unsigned DW = SAMPLE_W,
    parameter int unsigned AW = 3
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic [DW-1:0] i_din,
    output logic [DW-1:0] o_dout,
    output logic [AW:0]   o_level,
    output logic          o_full,
    output logic          o_empty
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_level;
    logic [DW-1:0] r_dout;

    logic          w_full;
    logic          w_empty;
    logic          w_push_ok;
    logic          w_pop_ok;
    logic [AW:0]   w_level_nxt;

    assign w_full    = (r_level == (AW + 1)'(DEPTH));
    assign w_empty   = (r_level == '0);
    assign w_pop_ok  = i_pop && !w_empty;
    assign w_push_ok = i_push && (!w_full || i_pop);

    always_comb begin
        w_level_nxt = r_level;
        unique case ({w_push_ok, w_pop_ok})
            2'b10:   w_level_nxt = r_level + 1'b1;
            2'b01:   w_level_nxt = r_level - 1'b1;
            default: w_level_nxt = r_level;
        endcase
    end

    // Storage carries no reset; only pointers and occupancy define validity.
    always_ff @(posedge i_clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_dout   <= '0;
        end else begin
            r_level <= w_level_nxt;
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_dout   <= r_mem[r_rd_ptr];
            end
        end
    end

    assign o_dout  = r_dout;
    assign o_level = r_level;
    assign o_full  = w_full;
    assign o_empty = w_empty;

endmodule

// File: rtl/uart_sample_packer.sv
// Pairs UART bytes into signed 16-bit little-endian samples and buffers them for the
// audio block, with sticky overflow/underrun flags and idle-gap pairing resync.
module uart_sample_packer
    import uart_sample_packer_pkg::*;
#(
    parameter int unsigned FIFO_AW      = DEF_FIFO_AW,
    parameter int unsigned IDLE_TIMEOUT = DEF_IDLE_TIMEOUT
) (
    input  logic                 i_clk50mhz,
    input  logic                 i_rst_n,
    uart_sample_packer_if.slave  bus
);

    localparam int unsigned CNT_W = (IDLE_TIMEOUT > 2) ? $clog2(IDLE_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IDLE_TIMEOUT - 1);

    pair_state_e         r_state;
    pair_state_e         w_state_nxt;
    logic [BYTE_W-1:0]   r_lo_byte;
    logic [CNT_W-1:0]    r_idle_cnt;
    logic [CNT_W-1:0]    w_cnt_inc;
    logic                w_timeout;

    logic                w_lo_load;
    logic                w_push;
    logic                w_cnt_run;

    logic [SAMPLE_W-1:0] w_din;
    logic [SAMPLE_W-1:0] w_dout;
    logic [FIFO_AW:0]    w_level;
    logic                w_full;
    logic                w_empty;

    logic                w_ovf_evt;
    logic                w_und_evt;
    logic                r_sample_valid;
    logic                r_overflow;
    logic                r_underrun;

    assign w_cnt_inc = r_idle_cnt + 1'b1;
    // Leave WAIT_HI on the edge where the counter would reach its last value, so the
    // pairing is back in WAIT_LO exactly IDLE_TIMEOUT cycles after the low byte.
    assign w_timeout = (r_state == WAIT_HI) && !bus.rx_valid && (w_cnt_inc == CNT_LAST);

    always_ff @(posedge i_clk50mhz or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= WAIT_LO;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            WAIT_LO: begin
                if (bus.rx_valid) begin
                    w_state_nxt = WAIT_HI;
                end
            end
            WAIT_HI: begin
                if (bus.rx_valid || w_timeout) begin
                    w_state_nxt = WAIT_LO;
                end
            end
            default: w_state_nxt = WAIT_LO;
        endcase
    end

    always_comb begin
        w_lo_load = 1'b0;
        w_push    = 1'b0;
        w_cnt_run = 1'b0;
        unique case (r_state)
            WAIT_LO: w_lo_load = bus.rx_valid;
            WAIT_HI: begin
                w_push    = bus.rx_valid;
                w_cnt_run = !bus.rx_valid;
            end
            default: begin
                w_lo_load = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk50mhz or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_lo_byte  <= '0;
            r_idle_cnt <= '0;
        end else begin
            if (w_lo_load) begin
                r_lo_byte  <= bus.rx_data;
                r_idle_cnt <= '0;
            end else if (w_cnt_run && (r_idle_cnt != CNT_LAST)) begin
                r_idle_cnt <= w_cnt_inc;
            end
        end
    end

    assign w_din = pack_sample(bus.rx_data, r_lo_byte);

    sample_fifo #(
        .DW (SAMPLE_W),
        .AW (FIFO_AW)
    ) u_fifo (
        .i_clk   (i_clk50mhz),
        .i_rst_n (i_rst_n),
        .i_push  (w_push),
        .i_pop   (bus.sample_req),
        .i_din   (w_din),
        .o_dout  (w_dout),
        .o_level (w_level),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // A pop in the same cycle frees the slot, so only an unpopped full FIFO drops.
    assign w_ovf_evt = w_push && w_full && !bus.sample_req;
    assign w_und_evt = bus.sample_req && w_empty;

    always_ff @(posedge i_clk50mhz or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sample_valid <= 1'b0;
            r_overflow     <= 1'b0;
            r_underrun     <= 1'b0;
        end else begin
            r_sample_valid <= bus.sample_req && !w_empty;
            r_overflow     <= (r_overflow && !bus.clear) || w_ovf_evt;
            r_underrun     <= (r_underrun && !bus.clear) || w_und_evt;
        end
    end

    assign bus.sample       = w_dout;
    assign bus.sample_valid = r_sample_valid;
    assign bus.level        = w_level;
    assign bus.overflow     = r_overflow;
    assign bus.underrun     = r_underrun;

endmodule

// File: doc/uart_sample_packer.md
# uart_sample_packer

Downstream stage of the 9600-baud UART receiver on the DE2-115 audio path. Pairs received bytes into signed 16-bit little-endian audio samples and buffers them in a small FIFO. Hands one sample to the audio output block on each sample request. Reports overflow and underrun with sticky flags and resynchronises byte pairing after a line-idle gap.

## Interface
Parameters:
- FIFO_AW, 3: FIFO address width; depth = 2^FIFO_AW samples (default 8).
- IDLE_TIMEOUT, 78125: CLK50MHz cycles without a byte (1.5 byte times at 9600 8N1) after which a pending low byte is discarded.

Ports:
- CLK50MHz  in  1  system clock, 50 MHz; the only clock.
- RST_N  in  1  asynchronous, active-low reset.
- RX_DATA  in  8  received byte from the UART receiver.
- RX_VALID  in  1  one-cycle strobe; RX_DATA valid this cycle.
- SAMPLE_REQ  in  1  one-cycle strobe from the audio block requesting the next sample.
- CLEAR  in  1  synchronous clear of the sticky flags only.
- SAMPLE  out  16  current sample to the audio block.
- SAMPLE_VALID  out  1  one-cycle strobe; SAMPLE updated from the FIFO.
- LEVEL  out  FIFO_AW+1  FIFO occupancy, 0..2^FIFO_AW.
- OVERFLOW  out  1  sticky; a completed sample was dropped because the FIFO was full.
- UNDERRUN  out  1  sticky; SAMPLE_REQ arrived with the FIFO empty.

## Operation
- Pairing FSM, states WAIT_LO and WAIT_HI; reset state is WAIT_LO.
  - WAIT_LO + RX_VALID: latch the low byte, clear the idle counter, go to WAIT_HI.
  - WAIT_HI + RX_VALID: form {RX_DATA, low byte}, issue a push, go to WAIT_LO.
  - WAIT_HI with no RX_VALID: the idle counter increments. When it reaches IDLE_TIMEOUT-1, discard the low byte and go to WAIT_LO. No push occurs.
  - The idle counter saturates and does not run in WAIT_LO.
- FIFO push:
  - Accepted if not full, or if a pop occurs in the same cycle.
  - Otherwise the sample is dropped and OVERFLOW is set.
- FIFO pop on SAMPLE_REQ:
  - If LEVEL > 0: SAMPLE <= head and SAMPLE_VALID pulses.
  - If LEVEL == 0: SAMPLE holds its last value, no SAMPLE_VALID, UNDERRUN is set.
  - A push in the same cycle does not bypass into the empty pop; that sample stays in the FIFO.
- LEVEL:
  - Push only: +1. Pop only: -1.
  - Push and pop together: unchanged.
- Pointers are FIFO_AW bits and wrap modulo the depth. LEVEL carries the extra bit that distinguishes full from empty.
- CLEAR resets OVERFLOW and UNDERRUN. If a new overflow or underrun occurs in the same cycle as CLEAR, the flag ends up set (set wins).
- Reset values:
  - SAMPLE = 16'h0000; SAMPLE_VALID, LEVEL, OVERFLOW, UNDERRUN = 0.
  - FSM in WAIT_LO; pointers and idle counter 0.
  - FIFO contents are don't-care.
- Reset asserted mid-pair or mid-operation abandons everything immediately, with no partial output.

## Timing
- RX_VALID (high byte) at cycle N: the sample is in the FIFO and LEVEL updates at N+1.
- SAMPLE_REQ at cycle M: SAMPLE and SAMPLE_VALID register at M+1. UNDERRUN sets at M+1.
- Earliest delivery is the high byte at N and SAMPLE_REQ at N+1, with SAMPLE valid at N+2.
- RX_VALID and SAMPLE_REQ may arrive on any cycles, including back-to-back and simultaneous; no stalls.
- Idle discard occurs exactly IDLE_TIMEOUT cycles after the low byte's RX_VALID.

## Structure
- Shared header `uart_audio_defs.vh`: FSM state localparams (WAIT_LO=1'b0, WAIT_HI=1'b1), SAMPLE_W=16, BYTE_W=8, default IDLE_TIMEOUT.
- One sub-module, `sample_fifo`:
  - parameters: DW=16, AW.
  - ports: push, pop, din, dout, level, full, empty.
  - Registered read; the same-cycle push/pop rules above are implemented inside it.
- The top level holds the pairing FSM, the idle counter, the sticky flags and the output register.

## Test plan
- Bytes 0x34, 0x12, then SAMPLE_REQ → SAMPLE=16'h1234, one SAMPLE_VALID pulse, LEVEL goes 0→1→0.
- 0xAA, then idle for IDLE_TIMEOUT cycles, then 0x78, 0x56, then SAMPLE_REQ → SAMPLE=16'h5678, LEVEL peaks at 1 (0xAA discarded). With 0x78 sent one cycle before timeout instead → sample 16'h78AA.
- Push 9 samples 0x0001..0x0009 with no requests → LEVEL=8, OVERFLOW=1. Nine pops return 0x0001..0x0008, then UNDERRUN=1 and SAMPLE stays 0x0008.
- FIFO full, completing high byte and SAMPLE_REQ in the same cycle → no overflow, LEVEL stays 8, oldest sample output.
- FIFO empty, SAMPLE_REQ with a completing push in the same cycle → UNDERRUN=1, no SAMPLE_VALID, LEVEL=1. CLEAR then drops UNDERRUN to 0.
- RST_N pulsed low mid-pair (WAIT_HI) with LEVEL=3 → all outputs at reset values immediately. The next byte pair produces a correct sample.
